// File: rtl/hex_char_sequencer.sv
// Round-robin shares a registered hex-digit converter between two 32-bit word requesters and
// streams each granted word as ASCII characters over valid/ready. Optional trailing space: HEX_SEP_EN.

module itoa (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] num,
  output logic [7:0] data
);

  // Registered nibble-to-ASCII conversion; "0".."9" then "A".."F".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= 8'h30;
    end else if (num < 4'd10) begin
      data <= 8'h30 + {4'h0, num};
    end else begin
      data <= 8'h37 + {4'h0, num};
    end
  end

endmodule

module hex_char_sequencer #(
  parameter int unsigned NIBBLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  output logic [1:0]  grant,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        char_last,
  output logic        busy
);

  localparam int unsigned SHAMT    = 4 * (8 - NIBBLES);
  localparam logic [2:0]  LAST_CNT = 3'(NIBBLES - 1);

`ifdef HEX_SEP_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_SEP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_gnt_q, last_gnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        win;
  logic        hs;
  logic        is_last;
  logic [7:0]  itoa_data;

  assign hs      = char_valid && char_ready;
  assign is_last = (cnt_q == LAST_CNT);
  assign grant   = grant_q;

  itoa u_itoa (
    .clk   (clk),
    .rst_n (rst_n),
    .num   (shift_q[31:28]),
    .data  (itoa_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      grant_q    <= grant_d;
    end
  end

  // Next-state: arbitration in IDLE, nibble stepping on each accepted character
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    grant_d    = 2'b00;
    win        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          win        = (req == 2'b11) ? ~last_gnt_q : req[1];
          shift_d    = (win ? word1 : word0) << SHAMT;
          cnt_d      = 3'd0;
          last_gnt_d = win;
          grant_d    = win ? 2'b10 : 2'b01;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_SEND;
      S_SEND: begin
        if (hs) begin
          if (!is_last) begin
            shift_d = shift_q << 4;
            cnt_d   = cnt_q + 3'd1;
            state_d = S_FETCH;
          end else begin
`ifdef HEX_SEP_EN
            state_d = S_SEP;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef HEX_SEP_EN
      S_SEP: if (hs) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so valid never sees ready
  always_comb begin
    char_valid = 1'b0;
    char_last  = 1'b0;
    char_data  = itoa_data;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_SEND: begin
        char_valid = 1'b1;
`ifndef HEX_SEP_EN
        char_last  = is_last;
`endif
      end
`ifdef HEX_SEP_EN
      S_SEP: begin
        char_valid = 1'b1;
        char_last  = 1'b1;
        char_data  = 8'h20;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hex_char_sequencer.sv
// Directed, table-driven bench for hex_char_sequencer: arbitration, character stream,
// backpressure, NIBBLES=2 instance and mid-word reset.

module tb_hex_char_sequencer;

`ifdef HEX_SEP_EN
  localparam int SEP = 1;
`else
  localparam int SEP = 0;
`endif
  localparam int NEXP = 8 + SEP;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] word0, word1;
  logic [1:0]  grant;
  logic [7:0]  char_data;
  logic        char_valid, char_ready, char_last, busy;

  logic [1:0]  req2;
  logic [31:0] word0_2, word1_2;
  logic [1:0]  grant2;
  logic [7:0]  char_data2;
  logic        char_valid2, char_ready2, char_last2, busy2;

  int checks;
  int failures;

  hex_char_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .word0      (word0),
    .word1      (word1),
    .grant      (grant),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_last  (char_last),
    .busy       (busy)
  );

  hex_char_sequencer #(.NIBBLES(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req2),
    .word0      (word0_2),
    .word1      (word1_2),
    .grant      (grant2),
    .char_data  (char_data2),
    .char_valid (char_valid2),
    .char_ready (char_ready2),
    .char_last  (char_last2),
    .busy       (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [1:0]  exp_grant;
    logic [63:0] exp_chars;
    bit          chk_lat;
    int          stall_at;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int got;
    bit done;
    logic [1:0] g;
    logic [7:0] exp_c;
    logic [63:0] ec;
    ec    = v.exp_chars;
    req   = req | v.req;
    word0 = v.w0;
    word1 = v.w1;
    g   = 2'b00;
    cyc = 0;
    while (g == 2'b00 && cyc < 20) begin
      @(posedge clk); #1;
      g = grant;
      cyc++;
    end
    check("grant", 32'(g), 32'(v.exp_grant));
    if (v.chk_lat) begin
      check("fetch_valid_low", 32'(char_valid), 32'd0);
      check("fetch_busy_high", 32'(busy), 32'd1);
    end
    req  = req & ~g;
    got  = 0;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (char_valid) begin
        exp_c = (got < 8) ? ec[63 - 8*got -: 8] : 8'h20;
        check("char_data", 32'(char_data), 32'(exp_c));
        check("char_last", 32'(char_last), 32'(got == NEXP - 1));
        if (got == 0) begin
          check("grant_pulse_1cyc", 32'(grant), 32'd0);
          if (v.chk_lat) check("first_valid_latency", 32'(cyc), 32'd1);
        end
        if (got == v.stall_at) begin
          char_ready = 1'b0;
          repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(char_valid), 32'd1);
            check("bp_data", 32'(char_data), 32'(exp_c));
          end
          char_ready = 1'b1;
        end
        got++;
        if (char_last || got > NEXP) done = 1'b1;
      end
    end
    check("char_count", 32'(got), 32'(NEXP));
  endtask

  initial begin
    int cyc;
    int got;
    logic [7:0] c2 [3];
    logic       l2 [3];

    checks   = 0;
    failures = 0;
    vecs[0] = '{2'b11, 32'h00000000, 32'hFFFFFFFF, 2'b01, "00000000", 1'b1, -1};
    vecs[1] = '{2'b00, 32'h00000000, 32'hFFFFFFFF, 2'b10, "FFFFFFFF", 1'b0, -1};
    vecs[2] = '{2'b11, 32'h00000000, 32'hFFFFFFFF, 2'b01, "00000000", 1'b0, -1};
    vecs[3] = '{2'b00, 32'h00000000, 32'hFFFFFFFF, 2'b10, "FFFFFFFF", 1'b0, -1};
    vecs[4] = '{2'b01, 32'h1234ABCD, 32'h00000000, 2'b01, "1234ABCD", 1'b1, -1};
    vecs[5] = '{2'b10, 32'h00000000, 32'hDEADBEEF, 2'b10, "DEADBEEF", 1'b0, -1};
    vecs[6] = '{2'b01, 32'h1234ABCD, 32'h00000000, 2'b01, "1234ABCD", 1'b0, 2};
    vecs[7] = '{2'b11, 32'h89ABCDEF, 32'h76543210, 2'b10, "76543210", 1'b0, -1};
    vecs[8] = '{2'b00, 32'h89ABCDEF, 32'h76543210, 2'b01, "89ABCDEF", 1'b0, -1};

    rst_n       = 1'b0;
    req         = 2'b00;
    word0       = '0;
    word1       = '0;
    char_ready  = 1'b1;
    req2        = 2'b00;
    word0_2     = '0;
    word1_2     = '0;
    char_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_valid", 32'(char_valid), 32'd0);
    check("rst_last", 32'(char_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(char_data), 32'h30);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset during the 4th character of 1234ABCD
    @(posedge clk); #1;
    req   = 2'b01;
    word0 = 32'h1234ABCD;
    cyc   = 0;
    while (grant == 2'b00 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_seq_grant", 32'(grant), 32'd1);
    req = 2'b00;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (char_valid) got++;
    end
    check("rst_seq_4th_char", 32'(char_data), 32'h34);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(char_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_last", 32'(char_last), 32'd0);
    check("midrst_data", 32'(char_data), 32'h30);
    #2 rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("post_rst_idle_valid", 32'(char_valid), 32'd0);
      check("post_rst_idle_busy", 32'(busy), 32'd0);
      check("post_rst_idle_grant", 32'(grant), 32'd0);
    end

    // NIBBLES=2 instance: word1 = E7
    req2    = 2'b10;
    word1_2 = 32'h000000E7;
    cyc     = 0;
    grant_wait: while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (grant2 != 2'b00) break;
    end
    check("n2_grant", 32'(grant2), 32'd2);
    req2 = 2'b00;
    got  = 0;
    cyc  = 0;
    while (got < 3 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (char_valid2) begin
        c2[got] = char_data2;
        l2[got] = char_last2;
        got++;
        if (char_last2) break;
      end
    end
    check("n2_count", 32'(got), 32'(2 + SEP));
    if (got >= 2) begin
      check("n2_char0", 32'(c2[0]), 32'h45);
      check("n2_last0", 32'(l2[0]), 32'd0);
      check("n2_char1", 32'(c2[1]), 32'h37);
      check("n2_last1", 32'(l2[1]), 32'(SEP == 0));
    end
    if (SEP == 1 && got == 3) begin
      check("n2_sep", 32'(c2[2]), 32'h20);
      check("n2_sep_last", 32'(l2[2]), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_char_sequencer.md
# hex_char_sequencer

Shares the registered hex-digit converter `itoa` between two 32-bit word requesters, for example a PC monitor and a register-value monitor. It arbitrates round-robin between them, captures the granted word, and feeds its nibbles MSB-first through the converter. It then emits the resulting ASCII characters one per valid/ready handshake to the downstream text/display writer. It sits between the CPU debug taps and the character sink in the single-cycle debug display path.

## Interface

Parameters:

- `NIBBLES`, default 8: nibbles emitted per word, MSB-first; legal range 1..8.

Ports:

- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous, active-low.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  2  per-requester request; held high until the matching `grant` pulse.
- `word0`  in  32  requester 0 data; must be stable while `req[0]` is high.
- `word1`  in  32  requester 1 data; must be stable while `req[1]` is high.
- `grant`  out  2  one-hot, one-cycle pulse marking the cycle the word was captured.
- `char_data`  out  8  ASCII character: "0".."9", "A".."F", or separator.
- `char_valid`  out  1  `char_data` is valid.
- `char_ready`  in  1  sink accepts `char_data` on a cycle where `char_valid && char_ready`.
- `char_last`  out  1  qualifies the final character of the current word.
- `busy`  out  1  high in every state except IDLE.

## Operation

- Internal state: `shift[31:0]`, a nibble counter `cnt[2:0]`, a round-robin pointer `last_gnt`, and a state register.
- Internally instantiates `itoa`. Its `num` input is driven from `shift[31:28]`; `itoa.data` drives `char_data`.
- State IDLE:
  - If `req != 0`, arbitrate. A single requester wins outright.
  - If both request, the requester other than `last_gnt` wins.
  - On that edge: load the winner's word left-aligned (`shift <= word << (4*(8-NIBBLES))`), set `cnt <= 0`, update `last_gnt`, pulse `grant`, and go to FETCH.
- State FETCH: `shift[31:28]` is presented to `itoa`. Next edge: go to SEND; `itoa.data` is now valid.
- State SEND:
  - `char_valid = 1`; `char_last = (cnt == NIBBLES-1)` when the separator feature is compiled out.
  - On handshake, if not the last nibble: `shift <= shift << 4`, `cnt <= cnt + 1`, go to FETCH.
  - On handshake of the last nibble: go to SEP if the separator feature is compiled in, else to IDLE.
  - Without handshake: hold all state. `char_data` stays stable because `num` is unchanged.
- State SEP (separator feature only): `char_data = 8'h20`, `char_valid = 1`, `char_last = 1`. On handshake go to IDLE.
- Requests are not sampled outside IDLE. A `req` that drops after its grant is ignored; the captured word completes.
- `char_valid` never depends combinationally on `char_ready`.

## Timing

- Reset values: `grant = 0`, `char_valid = 0`, `char_last = 0`, `busy = 0`, state IDLE, `cnt = 0`, `shift = 0`, `last_gnt = 1` (so requester 0 wins the first tie). `char_data` resets to "0" (`8'h30`).
- `req` sampled high at edge E: `grant` and `busy` are high in cycle E+1 (FETCH), and the first `char_valid` is in cycle E+2.
- Throughput with `char_ready` held high: 2 cycles per character. A full 8-nibble word takes 16 cycles from `grant` to the return to IDLE, plus 1 cycle with the separator.
- After the last handshake, the state is IDLE for one cycle before any new grant can occur. Back-to-back words are therefore spaced by 1 idle cycle.
- Reset mid-word: immediate abort, with outputs at their reset values on assertion. Nothing resumes after release; the requester must re-request.

## Configuration

- `HEX_SEP_EN` defined:
  - After the last nibble, SEP emits one space character (`8'h20`).
  - `char_last` moves to the separator character.
- `HEX_SEP_EN` undefined:
  - The SEP state is absent.
  - `char_last` is asserted on the final hex digit.

## Test plan

- Basic word: `req[0]` with `word0 = 32'h1234ABCD`, `char_ready` held at 1 -> `grant = 2'b01` for 1 cycle.
  - Characters are "1","2","3","4","A","B","C","D".
  - `char_last` is high only on "D" (or on `8'h20` with `HEX_SEP_EN`).
  - First `char_valid` appears 2 cycles after `req` is sampled.
- Tie arbitration: `req = 2'b11` from reset, `word0 = 32'h00000000`, `word1 = 32'hFFFFFFFF`, both held -> the word0 stream of "0"s is followed by the word1 stream of "F"s. A third grant goes to requester 0 again.
- Backpressure: `char_ready` held low for 5 cycles while the 3rd character "3" of `32'h1234ABCD` is valid -> `char_data = 8'h33` and `char_valid` stay constant, and no character is lost or duplicated.
- Parameter: `NIBBLES = 2`, `word1 = 32'h000000E7` -> characters "E","7", with `char_last` on "7".
- Reset mid-operation: assert `rst_n = 0` during the 4th character -> `char_valid = 0` and `busy = 0` asynchronously. After release with no `req`, the block stays in IDLE with no output.
- Request drop: `req[1]` deasserted in the cycle after its grant -> all 8 characters of `word1` are still emitted.
